// File: rtl/char_overlay.sv
// Text-overlay stage: paints font-ROM glyph pixels of a fixed character window
// onto the delayed VGA bus, with an optional blinking inverted cursor cell.
module char_overlay #(
  parameter int unsigned RECT_X       = 0,
  parameter int unsigned RECT_Y       = 0,
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 16,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] tbus_in,
  input  logic [7:0]  char_pixels,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic        blink_on,
  output logic [37:0] tbus_out
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] WIN_W = 11'(COLS * 8);
  localparam logic [10:0] WIN_H = 11'(ROWS * 16);

  logic [37:0]      tbus_out_q, tbus_out_d;
  logic             blink_on_q, blink_on_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vsync_prev_q, vsync_prev_d;

  logic [10:0] hcount, vcount;
  logic [11:0] dx_full, dy_full;
  logic        in_rect, px, cur_hit, blank;
  logic [11:0] rgb_d;

  // Window hit test; the extra borrow bit keeps underflow out of the window.
  always_comb begin
    hcount  = tbus_in[37:27];
    vcount  = tbus_in[24:14];
    blank   = tbus_in[25] | tbus_in[12];
    dx_full = {1'b0, hcount} - {1'b0, 11'(RECT_X)};
    dy_full = {1'b0, vcount} - {1'b0, 11'(RECT_Y)};
    in_rect = !dx_full[11] && (dx_full[10:0] < WIN_W) &&
              !dy_full[11] && (dy_full[10:0] < WIN_H);
    px      = char_pixels[~dx_full[2:0]];
    cur_hit = cursor_en & blink_on_q &
              (dx_full[9:3] == cursor_col) & (dy_full[9:4] == cursor_row);
  end

  // Pixel colour selection and bus register input.
  always_comb begin
    rgb_d = tbus_in[11:0];
    if (!blank && in_rect) begin
      if (px ^ cur_hit) begin
        rgb_d = FG_RGB;
      end else if (cur_hit && px) begin
        rgb_d = 12'h000;
      end
    end
    tbus_out_d = {tbus_in[37:12], rgb_d};
  end

  // Frame counter advances once per vsync rising edge; blink toggles on wrap.
  always_comb begin
    vsync_prev_d = tbus_in[13];
    cnt_d        = cnt_q;
    blink_on_d   = blink_on_q;
    if (tbus_in[13] && !vsync_prev_q) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbus_out_q   <= '0;
      blink_on_q   <= 1'b0;
      cnt_q        <= '0;
      vsync_prev_q <= 1'b0;
    end else begin
      tbus_out_q   <= tbus_out_d;
      blink_on_q   <= blink_on_d;
      cnt_q        <= cnt_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign tbus_out = tbus_out_q;
  assign blink_on = blink_on_q;

endmodule

// File: tb/tb_char_overlay.sv
// Directed bench for char_overlay: two instances (origin window, offset window)
// driven from shared inputs, checked against hand-computed expected buses.
module tb_char_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] tbus_in;
  logic [7:0]  char_pixels;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        blink_a, blink_b;
  logic [37:0] out_a, out_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  char_overlay #(
    .RECT_X(0), .RECT_Y(0), .COLS(16), .ROWS(16),
    .FG_RGB(12'hFFF), .BLINK_FRAMES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .tbus_in(tbus_in), .char_pixels(char_pixels),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .blink_on(blink_a), .tbus_out(out_a)
  );

  char_overlay #(
    .RECT_X(100), .RECT_Y(20), .COLS(4), .ROWS(2),
    .FG_RGB(12'hABC), .BLINK_FRAMES(1)
  ) dut_b (
    .clk(clk), .rst(rst), .tbus_in(tbus_in), .char_pixels(char_pixels),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .blink_on(blink_b), .tbus_out(out_b)
  );

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic [10:0] hc, input logic hs, input logic hb,
                                     input logic [10:0] vc, input logic vs, input logic vb,
                                     input logic [11:0] rgb);
    return {hc, hs, hb, vc, vs, vb, rgb};
  endfunction

  // Apply one pixel at a negedge, return at the following negedge.
  task automatic drive(input logic [37:0] bus, input logic [7:0] pix);
    tbus_in     = bus;
    char_pixels = pix;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic vs_pulse(input int hi);
    repeat (hi) drive(mk(11'd0, 1'b0, 1'b1, 11'd500, 1'b1, 1'b1, 12'h000), 8'h00);
    repeat (2) drive(mk(11'd0, 1'b0, 1'b1, 11'd500, 1'b0, 1'b1, 12'h000), 8'h00);
  endtask

  logic [37:0] v;

  initial begin
    rst         = 1'b1;
    tbus_in     = '0;
    char_pixels = '0;
    cursor_en   = 1'b0;
    cursor_col  = 7'd2;
    cursor_row  = 6'd1;
    #1;
    check("reset_out_a", out_a, 38'd0);
    check("reset_blink_a", 38'(blink_a), 38'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Passthrough: left of the offset window, and right of the origin window.
    v = mk(11'd50, 1'b1, 1'b0, 11'd30, 1'b0, 1'b0, 12'h0F0);
    drive(v, 8'hFF);
    check("pass_b_left", out_b, v);
    v = mk(11'd200, 1'b0, 1'b0, 11'd5, 1'b0, 1'b0, 12'h0F0);
    drive(v, 8'hFF);
    check("pass_a_right", out_a, v);

    // Glyph painting in the origin window.
    drive(mk(11'd3, 1'b0, 1'b0, 11'd5, 1'b0, 1'b0, 12'h123), 8'b0001_0000);
    check("glyph_on", out_a, mk(11'd3, 1'b0, 1'b0, 11'd5, 1'b0, 1'b0, 12'hFFF));
    drive(mk(11'd4, 1'b0, 1'b0, 11'd5, 1'b0, 1'b0, 12'h123), 8'b0001_0000);
    check("glyph_off", out_a, mk(11'd4, 1'b0, 1'b0, 11'd5, 1'b0, 1'b0, 12'h123));

    // Blanking suppresses painting.
    v = mk(11'd3, 1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 12'h123);
    drive(v, 8'b0001_0000);
    check("hblank", out_a, v);
    v = mk(11'd3, 1'b0, 1'b0, 11'd5, 1'b0, 1'b1, 12'h123);
    drive(v, 8'b0001_0000);
    check("vblank", out_a, v);

    // Offset-window edges: x 100..131, y 20..51.
    drive(mk(11'd100, 1'b0, 1'b0, 11'd20, 1'b0, 1'b0, 12'h111), 8'h80);
    check("b_first_px", out_b, mk(11'd100, 1'b0, 1'b0, 11'd20, 1'b0, 1'b0, 12'hABC));
    v = mk(11'd99, 1'b0, 1'b0, 11'd20, 1'b0, 1'b0, 12'h111);
    drive(v, 8'hFF);
    check("b_x_under", out_b, v);
    v = mk(11'd100, 1'b0, 1'b0, 11'd19, 1'b0, 1'b0, 12'h111);
    drive(v, 8'hFF);
    check("b_y_under", out_b, v);
    drive(mk(11'd131, 1'b0, 1'b0, 11'd51, 1'b0, 1'b0, 12'h111), 8'h01);
    check("b_last_px", out_b, mk(11'd131, 1'b0, 1'b0, 11'd51, 1'b0, 1'b0, 12'hABC));
    v = mk(11'd132, 1'b0, 1'b0, 11'd51, 1'b0, 1'b0, 12'h111);
    drive(v, 8'hFF);
    check("b_x_over", out_b, v);
    v = mk(11'd131, 1'b0, 1'b0, 11'd52, 1'b0, 1'b0, 12'h111);
    drive(v, 8'hFF);
    check("b_y_over", out_b, v);

    // Blink: a every 2 edges, b every edge; a long vsync counts once.
    vs_pulse(1);
    check("blink_a_e1", 38'(blink_a), 38'd0);
    check("blink_b_e1", 38'(blink_b), 38'd1);
    vs_pulse(1);
    check("blink_a_e2", 38'(blink_a), 38'd1);
    vs_pulse(100);
    check("blink_a_e3_long", 38'(blink_a), 38'd1);
    check("blink_b_e3_long", 38'(blink_b), 38'd1);
    vs_pulse(1);
    check("blink_a_e4", 38'(blink_a), 38'd0);
    vs_pulse(1);
    vs_pulse(1);
    check("blink_a_e6", 38'(blink_a), 38'd1);

    // Cursor at cell (2,1), glyph row F0.
    cursor_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(mk(11'(16 + i), 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, 12'h456), 8'hF0);
      check($sformatf("cur_on_%0d", i), out_a,
            mk(11'(16 + i), 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, (i < 4) ? 12'h000 : 12'hFFF));
    end
    cursor_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(mk(11'(16 + i), 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, 12'h456), 8'hF0);
      check($sformatf("cur_off_%0d", i), out_a,
            mk(11'(16 + i), 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, (i < 4) ? 12'hFFF : 12'h456));
    end
    cursor_en = 1'b1;
    v = mk(11'd128, 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, 12'h456);
    drive(v, 8'hFF);
    check("cur_col_edge", out_a, v);
    cursor_col = 7'd100;
    drive(mk(11'd16, 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, 12'h456), 8'h80);
    check("cur_out_range", out_a, mk(11'd16, 1'b0, 1'b0, 11'd16, 1'b0, 1'b0, 12'hFFF));
    cursor_col = 7'd2;

    // Asynchronous reset mid-line, then restart.
    #2 rst = 1'b1;
    #1;
    check("midreset_out_a", out_a, 38'd0);
    check("midreset_blink_a", 38'(blink_a), 38'd0);
    @(negedge clk);
    rst = 1'b0;
    v = mk(11'd200, 1'b1, 1'b0, 11'd7, 1'b0, 1'b0, 12'h789);
    drive(v, 8'hFF);
    check("post_reset_first", out_a, v);
    vs_pulse(1);
    check("post_reset_blink_a", 38'(blink_a), 38'd0);
    check("post_reset_blink_b", 38'(blink_b), 38'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
